// File: rtl/loader_def_jericalla.sv
`default_nettype none
// ============================================================================
// Module   : loader_def_jericalla
// Brief    : Boot loader that packs a length-prefixed byte stream into
//            big-endian 32-bit words for the instruction memory write port.
// Revision : 1.0
// ============================================================================
module loader_def_jericalla #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    parameter int          MAX_WORDS = 64
) (
    input  logic              clk_def_jericalla,
    input  logic              reset_def_jericalla,
    input  logic              start_def_jericalla,
    input  logic              byte_valid_def_jericalla,
    input  logic [7:0]        byte_def_jericalla,
    output logic              byte_ready_def_jericalla,
    output logic              mem_we_def_jericalla,
    output logic [ADDR_W-1:0] mem_addr_def_jericalla,
    output logic [31:0]       mem_data_def_jericalla,
    output logic              cpu_reset_def_jericalla,
    output logic              busy_def_jericalla,
    output logic              done_def_jericalla,
    output logic              error_def_jericalla
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [15:0] c_max_words = 16'(MAX_WORDS);

    logic [2:0]        r_state;
    logic [15:0]       r_len;
    logic [15:0]       r_k;
    logic [1:0]        r_b;
    logic [23:0]       r_word;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;

    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_len;
    logic [ADDR_W-1:0] w_word_addr;

    // Handshake-facing outputs decode from state only, so ready never
    // depends on valid.
    assign w_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA);
    assign w_accept    = w_ready && byte_valid_def_jericalla;
    assign w_len       = {r_len[15:8], byte_def_jericalla};
    assign w_word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({r_k, 2'b00});

    always_ff @(posedge clk_def_jericalla) begin
        if (reset_def_jericalla) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_k        <= '0;
            r_b        <= '0;
            r_word     <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_def_jericalla) begin
                        r_state <= S_LEN_HI;
                        r_len   <= '0;
                        r_k     <= '0;
                        r_b     <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= byte_def_jericalla;
                        r_state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= byte_def_jericalla;
                        if (w_len > c_max_words)
                            r_state <= S_ERROR;
                        else if (w_len == 16'd0)
                            r_state <= S_DONE;
                        else
                            r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= {r_word[15:0], byte_def_jericalla};
                        r_b    <= r_b + 2'd1;
                        // Latch the write port on the 4th byte so mem_we,
                        // addr and data all appear together in WRITE.
                        if (r_b == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_mem_addr <= w_word_addr;
                            r_mem_data <= {r_word, byte_def_jericalla};
                        end
                    end
                end
                S_WRITE: begin
                    r_k <= r_k + 16'd1;
                    r_b <= '0;
                    if (r_k + 16'd1 == r_len)
                        r_state <= S_DONE;
                    else
                        r_state <= S_DATA;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready_def_jericalla = w_ready;
    assign mem_we_def_jericalla     = (r_state == S_WRITE);
    assign mem_addr_def_jericalla   = r_mem_addr;
    assign mem_data_def_jericalla   = r_mem_data;
    assign cpu_reset_def_jericalla  = (r_state != S_DONE);
    assign busy_def_jericalla       = w_ready || (r_state == S_WRITE);
    assign done_def_jericalla       = (r_state == S_DONE);
    assign error_def_jericalla      = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: doc/loader_def_jericalla.md
# loader_def_jericalla

Boot-time program loader for the Jericalla datapath. It accepts a length-prefixed byte stream over a valid/ready handshake and packs it into big-endian 32-bit instruction words. It writes each word into the instruction memory write port at consecutive word addresses, and holds the datapath in reset until the whole image is written. It is the writer side of the instruction memory that the datapath reads from fetch.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- ADDR_W, 32, width of the memory address output.
- MAX_WORDS, 64, instruction memory capacity in words; larger images are rejected.

Ports:
- clk_def_jericalla  in  1  system clock, rising edge.
- reset_def_jericalla  in  1  synchronous, active-high reset.
- start_def_jericalla  in  1  single-cycle pulse that begins a load.
- byte_valid_def_jericalla  in  1  stream byte valid.
- byte_def_jericalla  in  8  stream byte.
- byte_ready_def_jericalla  out  1  loader can accept a byte this cycle.
- mem_we_def_jericalla  out  1  instruction memory write enable, one cycle per word.
- mem_addr_def_jericalla  out  ADDR_W  write byte address.
- mem_data_def_jericalla  out  32  write data.
- cpu_reset_def_jericalla  out  1  reset to the datapath; high while not loaded.
- busy_def_jericalla  out  1  load in progress.
- done_def_jericalla  out  1  sticky, image written successfully.
- error_def_jericalla  out  1  sticky, length exceeded MAX_WORDS.

## Operation
- Stream format: 16-bit word count N, sent high byte first. Then N×4 bytes, each word sent MSB first (big-endian).
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: on start goes to LEN_HI. Clears done and error, sets word index k=0 and byte index b=0.
- LEN_HI: accepts one byte into N[15:8], then goes to LEN_LO.
- LEN_LO: accepts one byte into N[7:0], then branches on N:
  - N>MAX_WORDS goes to ERROR.
  - N==0 goes to DONE.
  - Otherwise goes to DATA.
- DATA: each accepted byte shifts into the word register (word = {word[23:0], byte}) and increments b. Acceptance of the 4th byte (b==3) goes to WRITE.
- WRITE: asserts mem_we for exactly one cycle with:
  - mem_addr = BASE_ADDR + 4·k, truncated to ADDR_W;
  - mem_data = assembled word.
  - Then k increments and b clears. Next state is DONE if k+1==N, else DATA.
- DONE: done=1, cpu_reset=0. Holds until start or reset.
- ERROR: error=1, cpu_reset=1. Holds until start or reset. Nothing is written after entering ERROR.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE. In DONE or ERROR, start restarts a load: goes to LEN_HI and reasserts cpu_reset on the next cycle.
- busy is 1 in LEN_HI, LEN_LO, DATA and WRITE, and 0 otherwise.
- cpu_reset is 1 in every state except DONE.
- All outputs are registered, or decoded from the registered state only. No combinational path from byte_valid to byte_ready.

## Timing
- Reset values:
  - FSM state IDLE;
  - byte_ready=0, mem_we=0, mem_addr=0, mem_data=0;
  - cpu_reset=1, busy=0, done=0, error=0;
  - k=0, b=0, N=0.
- reset_def_jericalla mid-load aborts immediately and returns all outputs to their reset values. A partially written image is not erased.
- Handshake: a byte transfers on a rising edge when byte_valid && byte_ready. byte_ready=1 only in LEN_HI, LEN_LO and DATA. The source may hold byte_valid high across WRITE; that byte is accepted in the following DATA cycle.
- Peak throughput: 4 bytes every 5 cycles.
- Write latency: mem_we rises on the cycle after the edge that accepts the 4th byte of a word.
- The cycle after the final WRITE enters DONE, so cpu_reset falls one cycle after the last mem_we cycle.
- start pulse in IDLE: byte_ready rises on the next cycle.

## Test plan
- Reset then start; stream 00 02 | 20 08 00 05 | AC 08 00 04 -> mem_we pulses at addr 0 with data 32'h2008_0005, then at addr 4 with data 32'hAC08_0004. cpu_reset falls one cycle after the 2nd write and done=1.
- Stream 00 00 -> no mem_we; DONE reached after LEN_LO; cpu_reset=0, done=1, error=0.
- Stream 00 41 (65 > MAX_WORDS=64) -> ERROR; error=1, cpu_reset stays 1, no mem_we. A subsequent start followed by a valid 1-word image recovers to done=1 with error=0.
- byte_valid held high continuously for a 3-word image -> byte_ready=0 during each WRITE. Exactly 12 data bytes accepted, 3 writes at addr 0/4/8, no byte lost or duplicated.
- Assert reset_def_jericalla after 2 bytes of word 1 -> next cycle all outputs are at reset values, state is IDLE, cpu_reset=1. A following full load writes from addr BASE_ADDR.
- start pulsed during DATA -> ignored. Load completes normally with the expected address sequence.
